// File: rtl/uart_cmd_dispatcher_if.sv
// Bundle of the dispatcher's command, responder and transmitter signals.
// slave is the dispatcher side, master is the surrounding uart_rx/responder/uart_tx side.
interface uart_cmd_dispatcher_if #(
    parameter int unsigned N_RESP = 4
);
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic [N_RESP-1:0]     activate;
    logic [N_RESP-1:0]     done;
    logic [8*N_RESP-1:0]   resp_tx_data;
    logic [N_RESP-1:0]     resp_tx_start;
    logic [7:0]            tx_data;
    logic                  tx_start;
    logic                  busy;
    logic                  err_unknown;
    logic                  err_busy;
    logic                  err_timeout;

    modport master (
        output rx_valid, rx_data, done, resp_tx_data, resp_tx_start,
        input  activate, tx_data, tx_start, busy, err_unknown, err_busy, err_timeout
    );

    modport slave (
        input  rx_valid, rx_data, done, resp_tx_data, resp_tx_start,
        output activate, tx_data, tx_start, busy, err_unknown, err_busy, err_timeout
    );
endinterface

// File: rtl/uart_cmd_dispatcher.sv
// Decodes UART command bytes, runs one responder at a time through activate/done and
// owns the shared uart_tx. Optional command watchdog enabled by defining CMD_TIMEOUT_EN.
module uart_cmd_dispatcher #(
    parameter int unsigned N_RESP         = 4,
    parameter logic [7:0]  CMD_BASE       = 8'h41,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input logic                  clk_50mhz,
    input logic                  reset,
    uart_cmd_dispatcher_if.slave bus
);
    localparam int unsigned SEL_W = (N_RESP > 1) ? $clog2(N_RESP) : 1;
    localparam int unsigned WD_W  = 26;

    // Elaboration-time guard on the legal parameter ranges.
    if (N_RESP < 1 || N_RESP > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << WD_W)) begin : g_param_check
        $error("uart_cmd_dispatcher: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t            state;
    logic [SEL_W-1:0]  sel;
    logic [N_RESP-1:0] activate_q;
    logic              busy_q;
    logic              err_unknown_q;
    logic              err_busy_q;
    logic              err_timeout_q;
    logic [7:0]        tx_data_q;

    logic [7:0]        cmd_off_c;
    logic              cmd_hit_c;
    logic              sel_done_c;
    logic              sel_start_c;
    logic [7:0]        sel_data_c;
    logic              wd_expired_c;

    // Command offset wraps below CMD_BASE, so such bytes land far out of range.
    assign cmd_off_c   = bus.rx_data - CMD_BASE;
    assign cmd_hit_c   = (32'(cmd_off_c) < N_RESP);
    assign sel_done_c  = bus.done[sel];
    assign sel_start_c = bus.resp_tx_start[sel];
    assign sel_data_c  = bus.resp_tx_data[{sel, 3'b000} +: 8];

`ifdef CMD_TIMEOUT_EN
    logic [WD_W-1:0] watchdog;

    assign wd_expired_c = (watchdog == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog runs for the whole time a command is in flight.
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            watchdog <= '0;
        end else if (state == IDLE) begin
            watchdog <= '0;
        end else if (wd_expired_c) begin
            watchdog <= '0;
        end else begin
            watchdog <= watchdog + WD_W'(1);
        end
    end
`else
    assign wd_expired_c = 1'b0;
`endif

    // Command FSM with registered activate/busy/error outputs.
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            state         <= IDLE;
            sel           <= '0;
            activate_q    <= '0;
            busy_q        <= 1'b0;
            err_unknown_q <= 1'b0;
            err_busy_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            tx_data_q     <= 8'h00;
        end else begin
            err_unknown_q <= 1'b0;
            err_busy_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.rx_valid) begin
                        if (cmd_hit_c) begin
                            sel        <= SEL_W'(cmd_off_c);
                            activate_q <= N_RESP'(1) << cmd_off_c;
                            busy_q     <= 1'b1;
                            state      <= ACTIVE;
                        end else begin
                            err_unknown_q <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    tx_data_q <= sel_data_c;
                    if (bus.rx_valid) begin
                        err_busy_q <= 1'b1;
                    end
                    if (wd_expired_c) begin
                        activate_q    <= '0;
                        busy_q        <= 1'b0;
                        err_timeout_q <= 1'b1;
                        state         <= IDLE;
                    end else if (sel_done_c) begin
                        activate_q <= '0;
                        state      <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (bus.rx_valid) begin
                        err_busy_q <= 1'b1;
                    end
                    if (wd_expired_c) begin
                        busy_q        <= 1'b0;
                        err_timeout_q <= 1'b1;
                        state         <= IDLE;
                    end else if (!sel_done_c) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    activate_q <= '0;
                    busy_q     <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.activate    = activate_q;
    assign bus.busy        = busy_q;
    assign bus.err_unknown = err_unknown_q;
    assign bus.err_busy    = err_busy_q;
    assign bus.err_timeout = err_timeout_q;

    // Transmitter path is a zero-latency mux of the active responder only.
    assign bus.tx_start = (state == ACTIVE) ? sel_start_c : 1'b0;
    assign bus.tx_data  = (state == ACTIVE)  ? sel_data_c :
                          (state == RELEASE) ? tx_data_q  : 8'h00;
endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// Directed bench for uart_cmd_dispatcher: a small command model pushes expected
// activate patterns to a queue, popped and checked when the DUT raises activate.
module tb_uart_cmd_dispatcher;
    localparam int unsigned N_RESP = 4;
    localparam logic [7:0]  BASE   = 8'h41;

    logic clk_50mhz = 1'b0;
    logic reset     = 1'b1;
    logic run_mon   = 1'b0;
    logic model_busy = 1'b0;
    int   n_checks  = 0;
    int   n_errors  = 0;
    logic [N_RESP-1:0] exp_act_q[$];

    uart_cmd_dispatcher_if #(.N_RESP(N_RESP)) bus ();

    uart_cmd_dispatcher #(
        .N_RESP        (N_RESP),
        .CMD_BASE      (BASE),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_50mhz(clk_50mhz),
        .reset    (reset),
        .bus      (bus)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    task automatic step();
        @(posedge clk_50mhz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one rx byte; the model decides accept / unknown / busy and checks the result.
    task automatic send_cmd(input logic [7:0] b);
        logic [7:0]        d;
        logic              accept;
        logic              exp_unk;
        logic              exp_bsy;
        logic [N_RESP-1:0] exp_act;
        d       = b - BASE;
        accept  = !model_busy && (32'(d) < N_RESP);
        exp_unk = !model_busy && !(32'(d) < N_RESP);
        exp_bsy = model_busy;
        if (accept) begin
            exp_act_q.push_back(N_RESP'(1) << d);
            model_busy = 1'b1;
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        step();
        bus.rx_valid = 1'b0;
        check("err_unknown", 32'(bus.err_unknown), 32'(exp_unk));
        check("err_busy", 32'(bus.err_busy), 32'(exp_bsy));
        if (accept) begin
            exp_act = exp_act_q.pop_front();
            check("activate_on_accept", 32'(bus.activate), 32'(exp_act));
            check("busy_on_accept", 32'(bus.busy), 32'd1);
        end
    endtask

    // At most one responder may ever be active.
    always @(negedge clk_50mhz) begin
        if (run_mon) begin
            n_checks++;
            assert ($onehot0(bus.activate)) else begin
                n_errors++;
                $error("FAIL onehot_activate: observed=%0h expected=onehot0", bus.activate);
            end
        end
    end

    initial begin
        bus.rx_valid      = 1'b0;
        bus.rx_data       = 8'h00;
        bus.done          = '0;
        bus.resp_tx_data  = '0;
        bus.resp_tx_start = '0;
        reset = 1'b1;
        step();
        step();
        check("rst_activate", 32'(bus.activate), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_errs", {29'd0, bus.err_unknown, bus.err_busy, bus.err_timeout}, 32'd0);
        reset = 1'b0;
        run_mon = 1'b1;

        // Decode 0x43 -> responder 2, tx mux, done handshake.
        bus.resp_tx_data[23:16] = 8'h7F;
        bus.resp_tx_start[2]    = 1'b1;
        step();
        check("idle_tx_start", 32'(bus.tx_start), 32'd0);
        check("idle_tx_data", 32'(bus.tx_data), 32'd0);
        send_cmd(8'h43);
        check("r2_tx_data", 32'(bus.tx_data), 32'h7F);
        check("r2_tx_start", 32'(bus.tx_start), 32'd1);
        bus.done[2] = 1'b1;
        step();
        check("r2_release_act", 32'(bus.activate), 32'd0);
        check("r2_release_busy", 32'(bus.busy), 32'd1);
        check("r2_release_tx_start", 32'(bus.tx_start), 32'd0);
        check("r2_release_tx_data", 32'(bus.tx_data), 32'h7F);
        bus.done[2] = 1'b0;
        step();
        model_busy = 1'b0;
        check("r2_idle_busy", 32'(bus.busy), 32'd0);
        check("r2_idle_tx_data", 32'(bus.tx_data), 32'd0);
        bus.resp_tx_start = '0;

        // Unknown commands, including wrap below the base.
        send_cmd(8'h45);
        check("unk45_act", 32'(bus.activate), 32'd0);
        step();
        check("unk45_pulse_end", 32'(bus.err_unknown), 32'd0);
        send_cmd(8'h40);
        check("unk40_act", 32'(bus.activate), 32'd0);
        step();

        // Busy drop and isolation while responder 1 is active.
        bus.resp_tx_data[15:8] = 8'h5A;
        send_cmd(8'h42);
        send_cmd(8'h41);
        check("busy_drop_act", 32'(bus.activate), 32'h2);
        step();
        check("busy_pulse_end", 32'(bus.err_busy), 32'd0);
        bus.resp_tx_start[3]    = 1'b1;
        bus.resp_tx_data[31:24] = 8'hAA;
        bus.done[3]             = 1'b1;
        step();
        step();
        check("iso_tx_start", 32'(bus.tx_start), 32'd0);
        check("iso_tx_data", 32'(bus.tx_data), 32'h5A);
        check("iso_still_active", 32'(bus.activate), 32'h2);
        check("iso_busy", 32'(bus.busy), 32'd1);
        bus.resp_tx_start = '0;
        bus.done          = '0;
        bus.done[1]       = 1'b1;
        step();
        check("r1_release_act", 32'(bus.activate), 32'd0);
        // Byte arriving on the edge that returns to IDLE is still dropped.
        bus.done[1] = 1'b0;
        send_cmd(8'h41);
        model_busy = 1'b0;
        check("r1_idle_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_late_activation", 32'(bus.activate), 32'd0);
        end

        // Reset in the middle of a command.
        send_cmd(8'h41);
        bus.resp_tx_start[0] = 1'b1;
        #1;
        check("r0_tx_start", 32'(bus.tx_start), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_busy = 1'b0;
        check("midrst_act", 32'(bus.activate), 32'd0);
        check("midrst_tx_start", 32'(bus.tx_start), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        bus.resp_tx_start = '0;
        step();
        send_cmd(8'h41);
        bus.done[0] = 1'b1;
        step();
        bus.done[0] = 1'b0;
        step();
        model_busy = 1'b0;
        check("post_rst_cmd_done", 32'(bus.busy), 32'd0);

        // Watchdog behaviour.
        send_cmd(8'h41);
`ifdef CMD_TIMEOUT_EN
        for (int k = 1; k < 16; k++) begin
            step();
            check("wd_no_timeout_yet", 32'(bus.err_timeout), 32'd0);
            check("wd_still_active", 32'(bus.activate), 32'h1);
        end
        step();
        model_busy = 1'b0;
        check("wd_timeout_pulse", 32'(bus.err_timeout), 32'd1);
        check("wd_timeout_act", 32'(bus.activate), 32'd0);
        check("wd_timeout_busy", 32'(bus.busy), 32'd0);
        step();
        check("wd_pulse_end", 32'(bus.err_timeout), 32'd0);
`else
        for (int k = 0; k < 20; k++) begin
            step();
        end
        check("nowd_err_timeout", 32'(bus.err_timeout), 32'd0);
        check("nowd_still_active", 32'(bus.activate), 32'h1);
        check("nowd_still_busy", 32'(bus.busy), 32'd1);
        bus.done[0] = 1'b1;
        step();
        bus.done[0] = 1'b0;
        step();
        model_busy = 1'b0;
        check("nowd_done_busy", 32'(bus.busy), 32'd0);
`endif

        check("scoreboard_empty", 32'(exp_act_q.size()), 32'd0);
        run_mon = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_cmd_dispatcher.md
Name: uart_cmd_dispatcher

Overview:
- Decodes command bytes from the UART receiver.
- For each valid command, runs exactly one responder module (e.g. offset or sample readers) through its activate/done handshake.
- Owns the shared UART transmitter: only the active responder's tx_data/tx_start reach it.
- Sits between uart_rx, the responder modules and uart_tx; one command in flight at a time.

Parameters:
- N_RESP, 4: number of responder modules; legal range 1..16.
- CMD_BASE, 8'h41: command byte that selects responder 0. Responder i uses byte CMD_BASE+i.
- TIMEOUT_CYCLES, 50000000: watchdog limit in clk_50mhz cycles (1 s). Used only with CMD_TIMEOUT_EN.

Ports:
- clk_50mhz  in  1  system clock, all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received command byte.
- activate  out  N_RESP  one-hot activate to the responders.
- done  in  N_RESP  done flags from the responders.
- resp_tx_data  in  8*N_RESP  responder i's tx byte in bits [8i+7:8i].
- resp_tx_start  in  N_RESP  responder tx_start requests.
- tx_data  out  8  byte to uart_tx.
- tx_start  out  1  start strobe/level to uart_tx.
- busy  out  1  high while a command is being serviced.
- err_unknown  out  1  one-cycle pulse: command byte out of range.
- err_busy  out  1  one-cycle pulse: rx_valid arrived while busy; byte dropped.
- err_timeout  out  1  one-cycle pulse: watchdog expired.

Behaviour:
- Reset values, all outputs: activate=0, tx_data=0, tx_start=0, busy=0, all err_*=0.
- Reset values, internal: state=IDLE, sel=0, watchdog=0.
- A reset asserted mid-command drops activate on the next edge, discards the command and sends nothing further.

States:
- IDLE, busy=0:
  - On rx_valid, compute d = rx_data - CMD_BASE as 8-bit unsigned.
  - d < N_RESP: latch sel=d, go to ACTIVE. activate[sel] and busy go high on the next edge (1-cycle latency).
  - Otherwise: pulse err_unknown for 1 cycle and stay in IDLE. Wrap-around below CMD_BASE makes d large, so it counts as unknown.
- ACTIVE, busy=1:
  - activate = one-hot(sel), held.
  - tx_data = resp_tx_data[sel], tx_start = resp_tx_start[sel], combinational mux with no added latency.
  - When done[sel]=1 is sampled: activate goes 0 on the next edge and the state goes to RELEASE.
- RELEASE, busy=1:
  - activate=0, tx_start=0, tx_data holds its last muxed value.
  - When done[sel]=0 is sampled: go to IDLE on the next edge. A new command is accepted on the cycle IDLE is entered.

Rules in every state:
- Outside ACTIVE: tx_start=0. tx_data=0 in IDLE.
- done and resp_tx_start from non-selected responders are ignored in every state.
- rx_valid in ACTIVE or RELEASE: byte dropped, err_busy pulses 1 cycle, state unaffected.
- rx_valid on the same edge IDLE is entered: treated as busy (dropped, err_busy).
- At most one activate bit is high at any time.
- No activate bit is high in the cycle after reset or in IDLE.

Optional Feature:
CMD_TIMEOUT_EN
- Defined:
  - A 26-bit watchdog clears on IDLE->ACTIVE and increments every cycle in ACTIVE or RELEASE.
  - When it reaches TIMEOUT_CYCLES-1: on the next edge activate=0, tx_start=0, err_timeout pulses 1 cycle and the state goes to IDLE.
  - Timeout takes priority over done in the same cycle.
- Not defined:
  - No watchdog logic is built; err_timeout is tied 0.
  - ACTIVE and RELEASE wait indefinitely.

Test Plan:
- Decode and handshake:
  - Stimulus: N_RESP=4, rx_valid with rx_data=8'h43.
  - Response: activate=4'b0100 and busy=1 one cycle later. resp_tx_data[23:16]=8'h7F and resp_tx_start[2]=1 appear on tx_data/tx_start the same cycle.
  - Then: done[2]=1 -> activate=0 next cycle. done[2]=0 -> busy=0 next cycle.
- Unknown commands:
  - rx_data=8'h45 -> err_unknown 1-cycle pulse, activate stays 0.
  - rx_data=8'h40 (wraps to d=8'hFF) -> err_unknown pulse.
- Busy drop:
  - Stimulus: rx_valid=8'h41 while servicing 8'h42.
  - Response: err_busy pulse; activate stays 4'b0010; no responder 0 activation after completion.
- Isolation:
  - Stimulus: while sel=1, drive resp_tx_start[3]=1, resp_tx_data[31:24]=8'hAA and done[3]=1.
  - Response: tx_start stays 0, tx_data is unaffected, state stays ACTIVE.
- Reset mid-command:
  - Stimulus: reset asserted for 1 cycle during ACTIVE with sel=0.
  - Response: next edge gives activate=0, tx_start=0, busy=0. A following 8'h41 is serviced normally.
- Timeout (CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - Stimulus: command 8'h41, done[0] never asserted.
  - Response: err_timeout pulse and activate=0 exactly 16 cycles after activate rose, then busy=0.
